// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and baud arithmetic.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic int calc_os_div(input int clk_hz, input int baud);
    return (clk_hz + 8 * baud) / (16 * baud);
  endfunction

  // Bit value that completes the word's parity under the given mode.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// Free-running 16x oversampling divider: one tick every OS_DIV clocks.
module uart_tick_gen #(
  parameter int OS_DIV = 326
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CW'(OS_DIV - 1));
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_xcvr_param.sv
// Full-duplex UART: tick-paced TX FSM, 16x oversampled RX FSM with glitch reject,
// single-entry RX holding register with parity/framing/overrun flags, internal loopback.
module uart_xcvr_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232_rx,
  output logic                 rs232_tx,
  input  logic                 loopback,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int OS_DIV = calc_os_div(CLK_HZ, BAUD);
  // STOP leaves one tick early so a queued frame's start bit lands with no idle gap.
  localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BITS - 2);

  logic tick;
  uart_tick_gen #(.OS_DIV(OS_DIV)) u_tick (.clk_i(clk), .rst_i(rst), .tick_o(tick));

  uart_state_e          tx_state_q, tx_state_d;
  logic [4:0]           tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_pend_q, tx_pend_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_ready_q, tx_ready_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    tx_pend_d  = tx_pend_q;
    tx_line_d  = tx_line_q;
    unique case (tx_state_q)
      ST_IDLE: if (tx_valid && tx_ready_q) begin
        tx_data_d  = tx_data;
        tx_pend_d  = 1'b1;
        tx_state_d = ST_START;
      end
      ST_START: if (tick) begin
        if (tx_pend_q) begin
          tx_pend_d = 1'b0;
          tx_line_d = 1'b0;
          tx_cnt_d  = '0;
        end else if (tx_cnt_q == 5'd15) begin
          tx_state_d = ST_DATA;
          tx_line_d  = tx_data_q[0];
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else tx_cnt_d = tx_cnt_q + 5'd1;
      end
      ST_DATA: if (tick) begin
        if (tx_cnt_q == 5'd15) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'(DATA_BITS - 1)) begin
            if (PARITY != PAR_NONE) begin
              tx_state_d = ST_PARITY;
              tx_line_d  = parity_bit(8'(tx_data_q), PARITY);
            end else begin
              tx_state_d = ST_STOP;
              tx_line_d  = 1'b1;
            end
          end else begin
            tx_bit_d  = tx_bit_q + 3'd1;
            tx_line_d = tx_data_q[tx_bit_q + 3'd1];
          end
        end else tx_cnt_d = tx_cnt_q + 5'd1;
      end
      ST_PARITY: if (tick) begin
        if (tx_cnt_q == 5'd15) begin
          tx_state_d = ST_STOP;
          tx_line_d  = 1'b1;
          tx_cnt_d   = '0;
        end else tx_cnt_d = tx_cnt_q + 5'd1;
      end
      ST_STOP: if (tick) begin
        if (tx_cnt_q == STOP_LAST) tx_state_d = ST_IDLE;
        else                       tx_cnt_d   = tx_cnt_q + 5'd1;
      end
      default: tx_state_d = ST_IDLE;
    endcase
    tx_ready_d = (tx_state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_pend_q  <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_ready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_pend_q  <= tx_pend_d;
      tx_line_q  <= tx_line_d;
      tx_ready_q <= tx_ready_d;
    end
    tx_data_q <= tx_data_d;
  end

  // RX source select and 2-FF synchroniser; prev tracks the last synced level for
  // falling-edge detection, which also keeps a held break from re-arming.
  logic rx_sync1_q, rx_sync2_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= loopback ? tx_line_q : rs232_rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  uart_state_e          rx_state_q, rx_state_d;
  logic [3:0]           rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      ST_IDLE: if (!rx_sync2_q && rx_prev_q) begin
        rx_state_d = ST_START;
        rx_cnt_d   = '0;
      end
      ST_START: if (tick) begin
        if (rx_cnt_q == 4'd7) begin
          rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end else rx_cnt_d = rx_cnt_q + 4'd1;
      end
      ST_DATA: if (tick) begin
        if (rx_cnt_q == 4'd15) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == 3'(DATA_BITS - 1))
            rx_state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          else
            rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + 4'd1;
      end
      ST_PARITY: if (tick) begin
        if (rx_cnt_q == 4'd15) begin
          rx_par_d   = rx_sync2_q;
          rx_state_d = ST_STOP;
          rx_cnt_d   = '0;
        end else rx_cnt_d = rx_cnt_q + 4'd1;
      end
      ST_STOP: if (tick) begin
        if (rx_cnt_q == 4'd15) begin
          rx_done    = 1'b1;
          rx_state_d = ST_IDLE;
          rx_cnt_d   = '0;
        end else rx_cnt_d = rx_cnt_q + 4'd1;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
    end
    rx_shift_q <= rx_shift_d;
    rx_par_q   <= rx_par_d;
  end

  // Holding register: a same-cycle pop frees the slot for the completing frame.
  logic                 rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q, rx_pop, rx_perr_new;
  logic [DATA_BITS-1:0] rx_data_q;

  assign rx_pop      = rx_valid_q && rx_ready;
  assign rx_perr_new = (PARITY != PAR_NONE) && (rx_par_q != parity_bit(8'(rx_shift_q), PARITY));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_ovr_q <= 1'b0;
      if (rx_done && (!rx_valid_q || rx_pop)) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= rx_shift_q;
        rx_perr_q  <= rx_perr_new;
        rx_ferr_q  <= !rx_sync2_q;
      end else begin
        if (rx_done) rx_ovr_q   <= 1'b1;
        if (rx_pop)  rx_valid_q <= 1'b0;
      end
    end
  end

  assign rs232_tx      = loopback ? 1'b1 : tx_line_q;
  assign tx_ready      = tx_ready_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;
endmodule

// File: tb/tb_uart_xcvr_param.sv
// Bench for uart_xcvr_param (8E1, OS_DIV=4): vector table and random frames on the RX pin,
// random loopback traffic against a frame-level model, and hand-written corner sequences.
module tb_uart_xcvr_param;
  localparam int CLK_HZ    = 2_000_000;
  localparam int BAUD      = 31_250;
  localparam int DATA_BITS = 8;
  localparam int PARITY    = 2;
  localparam int STOP_BITS = 1;
  localparam int OSD       = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int BIT       = 16 * OSD;
  localparam int FRAME     = BIT * (1 + DATA_BITS + 1 + STOP_BITS);

  logic                 clk      = 1'b0;
  logic                 rst      = 1'b1;
  logic                 rs232_rx = 1'b1;
  logic                 rs232_tx;
  logic                 loopback = 1'b0;
  logic [DATA_BITS-1:0] tx_data  = '0;
  logic                 tx_valid = 1'b0;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready = 1'b1;
  logic                 rx_parity_err, rx_frame_err, rx_overrun;

  uart_xcvr_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .PARITY(PARITY), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk), .rst(rst), .rs232_rx(rs232_rx), .rs232_tx(rs232_tx), .loopback(loopback),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic pe; logic fe; } rxrec_t;
  typedef struct packed { logic [7:0] d; logic p; logic s; logic [7:0] ed; logic epe; logic efe; } vec_t;

  rxrec_t got_q[$];
  int checks   = 0;
  int failures = 0;
  int ovr_cnt  = 0;
  int lb_bad   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got_q.push_back('{d: rx_data, pe: rx_parity_err, fe: rx_frame_err});
      if (rx_overrun) ovr_cnt++;
      if (loopback && rs232_tx !== 1'b1) lb_bad++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Even-parity frame model: expected parity bit is 1 when the data has an odd count of ones.
  function automatic rxrec_t model(input logic [7:0] d, input logic p, input logic s);
    rxrec_t r;
    r.d  = d;
    r.pe = (p != ($countones(d) % 2 == 1));
    r.fe = !s;
    return r;
  endfunction

  task automatic send(input logic [7:0] d);
    int c;
    c = 0;
    @(negedge clk);
    while (!tx_ready && c < 3 * FRAME) begin
      @(negedge clk);
      c++;
    end
    chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rs232_rx = bits[i];
      repeat (BIT) @(posedge clk);
    end
    rs232_rx = 1'b1;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic wait_rx(input int n, input int max_cyc);
    int c;
    c = 0;
    while (got_q.size() < n && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    chk("rx_frame_count", got_q.size(), n);
  endtask

  task automatic check_next(input string tag, input rxrec_t e);
    rxrec_t r;
    wait_rx(1, 2 * FRAME);
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      chk({tag, "_data"}, r.d, e.d);
      chk({tag, "_perr"}, r.pe, e.pe);
      chk({tag, "_ferr"}, r.fe, e.fe);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[8];
    rxrec_t      e;
    logic [7:0]  txq[$];
    logic [7:0]  d;
    logic        p, s;
    int          base;

    vt[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vt[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vt[2] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    vt[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    vt[5] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[6] = '{8'h7F, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1};
    vt[7] = '{8'hB6, 1'b1, 1'b1, 8'hB6, 1'b0, 1'b0};

    // Reset state, then tx_ready one cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_line",  rs232_tx, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_data",  rx_data, 0);
    chk("rst_flags",    {rx_parity_err, rx_frame_err, rx_overrun}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_tx_ready", tx_ready, 1);

    // Loopback: single byte, then back-to-back random traffic.
    @(posedge clk);
    #1 loopback = 1'b1;
    send(8'hA5);
    check_next("lb_a5", '{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    txq = {8'h00, 8'hFF};
    for (int i = 0; i < 20; i++) txq.push_back(8'($urandom_range(0, 255)));
    foreach (txq[i]) send(txq[i]);
    wait_rx(txq.size(), 2 * FRAME);
    for (int i = 0; i < txq.size(); i++) begin
      if (got_q.size() == 0) break;
      e = got_q.pop_front();
      chk("lb_data", e.d, txq[i]);
      chk("lb_errs", {e.pe, e.fe}, 0);
    end
    chk("lb_overrun", ovr_cnt, 0);
    chk("lb_line_high", lb_bad, 0);
    @(posedge clk);
    #1 loopback = 1'b0;

    // External RX: vector table, then random frames against the model.
    for (int i = 0; i < 8; i++) begin
      drive_frame(vt[i].d, vt[i].p, vt[i].s);
      check_next("vec", '{d: vt[i].ed, pe: vt[i].epe, fe: vt[i].efe});
    end
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      drive_frame(d, p, s);
      check_next("rnd", model(d, p, s));
    end

    // Break: line low for 20 bit times gives exactly one frame.
    rs232_rx = 1'b0;
    repeat (20 * BIT) @(posedge clk);
    rs232_rx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    @(negedge clk);
    chk("brk_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      e = got_q.pop_front();
      chk("brk_data", e.d, 0);
      chk("brk_ferr", e.fe, 1);
    end

    // Overrun: consumer stalled across two frames.
    @(posedge clk);
    #1 rx_ready = 1'b0;
    base = ovr_cnt;
    drive_frame(8'h11, 1'b0, 1'b1);
    drive_frame(8'h22, 1'b0, 1'b1);
    @(negedge clk);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_held",  rx_data, 8'h11);
    chk("ovr_pulses", ovr_cnt - base, 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(negedge clk);
    chk("pop_valid_same", rx_valid, 1);
    @(negedge clk);
    chk("pop_valid_next", rx_valid, 0);
    check_next("pop", '{d: 8'h11, pe: 1'b0, fe: 1'b0});

    // Short low glitch is rejected.
    @(posedge clk);
    #1 rs232_rx = 1'b0;
    repeat (3 * OSD) @(posedge clk);
    #1 rs232_rx = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    @(negedge clk);
    chk("glitch_frames", got_q.size(), 0);
    chk("glitch_valid",  rx_valid, 0);

    // Reset in the middle of a TX frame.
    send(8'h00);
    repeat (2 * BIT) @(posedge clk);
    @(negedge clk);
    chk("mid_tx_low", rs232_tx, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_line",  rs232_tx, 1);
    chk("mid_rst_ready", tx_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready0", tx_ready, 0);
    @(negedge clk);
    chk("mid_rel_ready1", tx_ready, 1);
    repeat (2 * FRAME) @(posedge clk);
    @(negedge clk);
    chk("mid_idle_line", rs232_tx, 1);
    chk("mid_no_rx", got_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
